// File: rtl/vram_port_arbiter_if.sv
// Port-B bus of ram_block, shared by the display fetch engine and the canvas draw engine.
// master = engines plus RAM side, slave = the arbiter.
interface vram_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              draw_req;
  logic              draw_we;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_wdata;
  logic              draw_gnt;
  logic              draw_rvalid;
  logic [DATA_W-1:0] draw_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output disp_req, disp_addr, draw_req, draw_we, draw_addr, draw_wdata, mem_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata, draw_gnt, draw_rvalid, draw_rdata,
           mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  disp_req, disp_addr, draw_req, draw_we, draw_addr, draw_wdata, mem_rdata,
    output disp_gnt, disp_rvalid, disp_rdata, draw_gnt, draw_rvalid, draw_rdata,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Fixed-priority (display first) arbiter for ram_block port B with bounded-wait draw forcing.
// Optional grant/force statistics counters are enabled by defining ARB_STATS_EN.
module vram_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  vram_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]        disp_grant_cnt,
  output logic [31:0]        draw_grant_cnt,
  output logic [15:0]        force_cnt
`endif
);

  typedef enum logic {PRIO_DISP, FORCE_DRAW} state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_DRAW} tag_e;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  tag_e             tag_q [RD_LAT];
  tag_e             tag_d [RD_LAT];
  tag_e             tag_in;
  logic             disp_gnt, draw_gnt;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    disp_gnt     = 1'b0;
    draw_gnt     = 1'b0;
    state_d      = state_q;
    starve_cnt_d = '0;
    if (!reset) begin
      case (state_q)
        PRIO_DISP: begin
          disp_gnt = bus.disp_req;
          draw_gnt = bus.draw_req && !bus.disp_req;
          if (bus.draw_req && !draw_gnt)
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q
                                                        : starve_cnt_q + CNT_W'(1);
          if (starve_cnt_d == STARVE_LIM)
            state_d = FORCE_DRAW;
        end
        FORCE_DRAW: begin
          // Display is locked out for this one cycle even if draw has dropped its request.
          draw_gnt = bus.draw_req;
          state_d  = PRIO_DISP;
        end
        default: state_d = PRIO_DISP;
      endcase
    end
  end

  assign tag_in = disp_gnt                  ? TAG_DISP :
                  (draw_gnt && !bus.draw_we) ? TAG_DRAW : TAG_NONE;

  always_comb begin
    tag_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PRIO_DISP;
      starve_cnt_q <= '0;
      // NOTE: the tag pipeline is reset because stale tags would raise rvalid for dropped reads.
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= TAG_NONE;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tag_q        <= tag_d;
    end
  end

  assign bus.disp_gnt    = disp_gnt;
  assign bus.draw_gnt    = draw_gnt;
  assign bus.mem_we      = draw_gnt && bus.draw_we;
  assign bus.mem_addr    = disp_gnt ? bus.disp_addr :
                           draw_gnt ? bus.draw_addr : ADDR_W'(0);
  assign bus.mem_wdata   = draw_gnt ? bus.draw_wdata : DATA_W'(0);

  // Outputs are forced low during reset; the pipeline itself only clears at the edge.
  assign bus.disp_rvalid = !reset && (tag_q[RD_LAT-1] == TAG_DISP);
  assign bus.draw_rvalid = !reset && (tag_q[RD_LAT-1] == TAG_DRAW);
  assign bus.disp_rdata  = bus.disp_rvalid ? bus.mem_rdata : DATA_W'(0);
  assign bus.draw_rdata  = bus.draw_rvalid ? bus.mem_rdata : DATA_W'(0);

`ifdef ARB_STATS_EN
  logic [31:0] disp_grant_cnt_q, disp_grant_cnt_d;
  logic [31:0] draw_grant_cnt_q, draw_grant_cnt_d;
  logic [15:0] force_cnt_q, force_cnt_d;

  always_comb begin
    disp_grant_cnt_d = disp_grant_cnt_q + 32'(disp_gnt);
    draw_grant_cnt_d = draw_grant_cnt_q + 32'(draw_gnt);
    force_cnt_d      = force_cnt_q;
    if (state_q == PRIO_DISP && state_d == FORCE_DRAW && force_cnt_q != 16'hFFFF)
      force_cnt_d = force_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_grant_cnt_q <= '0;
      draw_grant_cnt_q <= '0;
      force_cnt_q      <= '0;
    end else begin
      disp_grant_cnt_q <= disp_grant_cnt_d;
      draw_grant_cnt_q <= draw_grant_cnt_d;
      force_cnt_q      <= force_cnt_d;
    end
  end

  assign disp_grant_cnt = disp_grant_cnt_q;
  assign draw_grant_cnt = draw_grant_cnt_q;
  assign force_cnt      = force_cnt_q;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: two instances (RD_LAT=1 and RD_LAT=2) driven by identical stimulus.
// Directed scenarios check fixed values; the random scenario checks against a transaction-level model.
module tb_vram_port_arbiter;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              disp_req, draw_req, draw_we;
  logic [ADDR_W-1:0] disp_addr, draw_addr;
  logic [DATA_W-1:0] draw_wdata, mem_rdata;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int cyc;
    int owner;
  } acc_t;

  vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
  vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

  assign bus1.disp_req   = disp_req;
  assign bus1.disp_addr  = disp_addr;
  assign bus1.draw_req   = draw_req;
  assign bus1.draw_we    = draw_we;
  assign bus1.draw_addr  = draw_addr;
  assign bus1.draw_wdata = draw_wdata;
  assign bus1.mem_rdata  = mem_rdata;
  assign bus2.disp_req   = disp_req;
  assign bus2.disp_addr  = disp_addr;
  assign bus2.draw_req   = draw_req;
  assign bus2.draw_we    = draw_we;
  assign bus2.draw_addr  = draw_addr;
  assign bus2.draw_wdata = draw_wdata;
  assign bus2.mem_rdata  = mem_rdata;

`ifdef ARB_STATS_EN
  logic [31:0] s1_disp_cnt, s1_draw_cnt, s2_disp_cnt, s2_draw_cnt;
  logic [15:0] s1_force_cnt, s2_force_cnt;
`endif

  vram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .STARVE_MAX(STARVE_MAX)
  ) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
`ifdef ARB_STATS_EN
    , .disp_grant_cnt(s1_disp_cnt), .draw_grant_cnt(s1_draw_cnt), .force_cnt(s1_force_cnt)
`endif
  );

  vram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .STARVE_MAX(STARVE_MAX)
  ) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
`ifdef ARB_STATS_EN
    , .disp_grant_cnt(s2_disp_cnt), .draw_grant_cnt(s2_draw_cnt), .force_cnt(s2_force_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req   = 1'b0;
    draw_req   = 1'b0;
    draw_we    = 1'b0;
    disp_addr  = '0;
    draw_addr  = '0;
    draw_wdata = '0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return {ADDR_W{1'b1}};
    return ADDR_W'($urandom);
  endfunction

  task automatic test_reset();
    reset     = 1'b1;
    disp_req  = 1'b1;
    draw_req  = 1'b1;
    draw_we   = 1'b1;
    disp_addr = 12'h3C3;
    draw_addr = 12'h5A5;
    for (int c = 0; c < 3; c++) begin
      mem_rdata = DATA_W'($urandom);
      @(negedge clk);
      n_run++;
      if ({bus1.disp_gnt, bus1.draw_gnt, bus1.mem_we, bus1.disp_rvalid, bus1.draw_rvalid,
           bus2.disp_gnt, bus2.draw_gnt, bus2.mem_we, bus2.disp_rvalid, bus2.draw_rvalid} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl: got %b %b %b %b %b / %b %b %b %b %b required all 0",
                 bus1.disp_gnt, bus1.draw_gnt, bus1.mem_we, bus1.disp_rvalid, bus1.draw_rvalid,
                 bus2.disp_gnt, bus2.draw_gnt, bus2.mem_we, bus2.disp_rvalid, bus2.draw_rvalid);
      end
      n_run++;
      if ((bus1.disp_rdata | bus1.draw_rdata | bus2.disp_rdata | bus2.draw_rdata) !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_rdata: got %h %h %h %h required 0",
                 bus1.disp_rdata, bus1.draw_rdata, bus2.disp_rdata, bus2.draw_rdata);
      end
      tick();
    end
    idle_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_disp_read();
    disp_req  = 1'b1;
    disp_addr = 12'h010;
    mem_rdata = 16'hBEEF;
    @(negedge clk);
    n_run++;
    if ({bus1.disp_gnt, bus1.draw_gnt, bus1.mem_we, bus1.mem_addr} !== {3'b100, 12'h010}) begin
      n_fail++;
      $display("FAIL disp_grant: got gnt=%b/%b we=%b addr=%h required 1/0 0 010",
               bus1.disp_gnt, bus1.draw_gnt, bus1.mem_we, bus1.mem_addr);
    end
    tick();
    disp_req = 1'b0;
    @(negedge clk);
    n_run++;
    if ({bus1.disp_rvalid, bus1.disp_rdata, bus1.draw_rvalid, bus2.disp_rvalid} !== {1'b1, 16'hBEEF, 2'b00}) begin
      n_fail++;
      $display("FAIL disp_ret_lat1: got rv=%b data=%h draw_rv=%b lat2_rv=%b required 1 beef 0 0",
               bus1.disp_rvalid, bus1.disp_rdata, bus1.draw_rvalid, bus2.disp_rvalid);
    end
    tick();
    @(negedge clk);
    n_run++;
    if ({bus1.disp_rvalid, bus1.disp_rdata, bus2.disp_rvalid, bus2.disp_rdata, bus2.draw_rvalid}
        !== {1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL disp_ret_lat2: got lat1 rv=%b d=%h lat2 rv=%b d=%h draw_rv=%b required 0 0000 1 beef 0",
               bus1.disp_rvalid, bus1.disp_rdata, bus2.disp_rvalid, bus2.disp_rdata, bus2.draw_rvalid);
    end
    tick();
    tick();
  endtask

  task automatic test_starvation();
    logic exp_draw, prev_draw;
    prev_draw = 1'b0;
    disp_req  = 1'b1;
    draw_req  = 1'b1;
    draw_we   = 1'b0;
    disp_addr = 12'h100;
    draw_addr = 12'h200;
    for (int c = 1; c <= 27; c++) begin
      exp_draw  = (c % 9 == 0);
      mem_rdata = DATA_W'($urandom);
      @(negedge clk);
      n_run++;
      if ({bus1.disp_gnt, bus1.draw_gnt, bus2.disp_gnt, bus2.draw_gnt, bus1.mem_addr}
          !== {!exp_draw, exp_draw, !exp_draw, exp_draw, exp_draw ? 12'h200 : 12'h100}) begin
        n_fail++;
        $display("FAIL starve_cycle%0d: got gnt d/w=%b%b %b%b addr=%h required %b%b",
                 c, bus1.disp_gnt, bus1.draw_gnt, bus2.disp_gnt, bus2.draw_gnt, bus1.mem_addr,
                 !exp_draw, exp_draw);
      end
      n_run++;
      if ({bus1.draw_rvalid, bus1.disp_rvalid} !== {prev_draw, (c > 1) && !prev_draw}) begin
        n_fail++;
        $display("FAIL starve_ret%0d: got draw_rv=%b disp_rv=%b required %b %b",
                 c, bus1.draw_rvalid, bus1.disp_rvalid, prev_draw, (c > 1) && !prev_draw);
      end
      prev_draw = exp_draw;
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_write_boundary();
    draw_req   = 1'b1;
    draw_we    = 1'b1;
    draw_addr  = 12'hFFF;
    draw_wdata = 16'h1234;
    @(negedge clk);
    n_run++;
    if ({bus1.draw_gnt, bus1.disp_gnt, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata}
        !== {3'b101, 12'hFFF, 16'h1234}) begin
      n_fail++;
      $display("FAIL write_fff: got gnt=%b/%b we=%b addr=%h wdata=%h required 1/0 1 fff 1234",
               bus1.draw_gnt, bus1.disp_gnt, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata);
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.draw_rvalid, bus1.disp_rvalid,
           bus2.draw_rvalid, bus2.disp_rvalid} !== 33'b0) begin
        n_fail++;
        $display("FAIL write_no_ret%0d: got we=%b addr=%h wdata=%h rv=%b%b%b%b required all 0",
                 c, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.draw_rvalid, bus1.disp_rvalid,
                 bus2.draw_rvalid, bus2.disp_rvalid);
      end
      tick();
    end
    // draw read at address 0 passes straight through and returns data
    draw_req  = 1'b1;
    draw_addr = 12'h000;
    mem_rdata = 16'h0F0F;
    @(negedge clk);
    n_run++;
    if ({bus1.draw_gnt, bus1.mem_we, bus1.mem_addr} !== {2'b10, 12'h000}) begin
      n_fail++;
      $display("FAIL read_addr0: got gnt=%b we=%b addr=%h required 1 0 000",
               bus1.draw_gnt, bus1.mem_we, bus1.mem_addr);
    end
    tick();
    idle_inputs();
    mem_rdata = 16'hC33C;
    @(negedge clk);
    n_run++;
    if ({bus1.draw_rvalid, bus1.draw_rdata} !== {1'b1, 16'hC33C}) begin
      n_fail++;
      $display("FAIL read_addr0_ret: got rv=%b data=%h required 1 c33c", bus1.draw_rvalid, bus1.draw_rdata);
    end
    tick();
    repeat (2) tick();
  endtask

  task automatic test_alternating();
    int g [0:11];
    logic [3:0] exp_rv, act_rv;
    for (int c = 0; c < 12; c++) begin
      idle_inputs();
      if (c < 8 && c % 2 == 0) begin disp_req = 1'b1; disp_addr = 12'h020; end
      if (c < 8 && c % 2 == 1) begin draw_req = 1'b1; draw_addr = 12'h021; end
      g[c] = (c >= 8) ? 0 : (c % 2 == 0) ? 1 : 2;
      mem_rdata = DATA_W'($urandom);
      @(negedge clk);
      exp_rv = {c >= 1 && g[c-1] == 1, c >= 1 && g[c-1] == 2, c >= 2 && g[c-2] == 1, c >= 2 && g[c-2] == 2};
      act_rv = {bus1.disp_rvalid, bus1.draw_rvalid, bus2.disp_rvalid, bus2.draw_rvalid};
      n_run++;
      if (act_rv !== exp_rv) begin
        n_fail++;
        $display("FAIL alt_rvalid%0d: got %b required %b", c, act_rv, exp_rv);
      end
      n_run++;
      if ({bus2.disp_rdata, bus2.draw_rdata} !==
          {exp_rv[1] ? mem_rdata : 16'h0, exp_rv[0] ? mem_rdata : 16'h0}) begin
        n_fail++;
        $display("FAIL alt_rdata%0d: got %h %h rv=%b mem=%h", c, bus2.disp_rdata, bus2.draw_rdata,
                 exp_rv[1:0], mem_rdata);
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    draw_req  = 1'b1;
    draw_we   = 1'b0;
    draw_addr = 12'h055;
    @(negedge clk);
    n_run++;
    if ({bus1.draw_gnt, bus2.draw_gnt} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_accept: got %b%b required 11", bus1.draw_gnt, bus2.draw_gnt);
    end
    tick();
    reset     = 1'b1;
    draw_req  = 1'b0;
    disp_req  = 1'b1;
    mem_rdata = 16'hA5A5;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus1.disp_gnt, bus1.draw_gnt, bus1.mem_we, bus1.disp_rvalid, bus1.draw_rvalid, bus1.draw_rdata,
           bus2.disp_gnt, bus2.draw_gnt, bus2.mem_we, bus2.disp_rvalid, bus2.draw_rvalid, bus2.draw_rdata}
          !== 42'b0) begin
        n_fail++;
        $display("FAIL mid_reset_out%0d: got gnt=%b%b rv=%b%b data=%h / gnt=%b%b rv=%b%b data=%h required 0",
                 c, bus1.disp_gnt, bus1.draw_gnt, bus1.disp_rvalid, bus1.draw_rvalid, bus1.draw_rdata,
                 bus2.disp_gnt, bus2.draw_gnt, bus2.disp_rvalid, bus2.draw_rvalid, bus2.draw_rdata);
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus1.draw_rvalid, bus2.draw_rvalid} !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_dropped%0d: got draw_rv=%b%b required 00", c, bus1.draw_rvalid, bus2.draw_rvalid);
      end
      tick();
    end
    // drive the FSM into FORCE_DRAW, then reset: display must win again afterwards
    disp_req = 1'b1;
    draw_req = 1'b1;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus1.disp_gnt, bus1.draw_gnt, bus2.disp_gnt, bus2.draw_gnt}
          !== {c != 9, c == 9, c != 9, c == 9}) begin
        n_fail++;
        $display("FAIL post_reset_prio%0d: got %b%b %b%b required %b%b", c, bus1.disp_gnt, bus1.draw_gnt,
                 bus2.disp_gnt, bus2.draw_gnt, c != 9, c == 9);
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_random();
    int   streak, now, own1, own2;
    bit   forced;
    acc_t acc [$];
    logic e_dg, e_wg, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [64:0] exp1, exp2, act1, act2;
    streak = 0;
    now    = 0;
    forced = 1'b0;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!disp_req) begin
        disp_req  = ($urandom_range(0, 99) < 60);
        disp_addr = rand_addr();
      end
      if (!draw_req) begin
        draw_req   = ($urandom_range(0, 99) < 60);
        draw_we    = 1'($urandom_range(0, 1));
        draw_addr  = rand_addr();
        draw_wdata = DATA_W'($urandom);
      end
      mem_rdata = DATA_W'($urandom);
      reset     = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      if (reset) begin
        e_dg = 1'b0; e_wg = 1'b0;
      end else if (forced) begin
        e_dg = 1'b0; e_wg = draw_req;
      end else begin
        e_dg = disp_req; e_wg = draw_req && !disp_req;
      end
      e_we    = e_wg && draw_we;
      e_addr  = e_dg ? disp_addr : e_wg ? draw_addr : '0;
      e_wdata = e_wg ? draw_wdata : '0;
      own1 = 0;
      own2 = 0;
      foreach (acc[i]) begin
        if (acc[i].cyc == now - 1) own1 = acc[i].owner;
        if (acc[i].cyc == now - 2) own2 = acc[i].owner;
      end
      if (reset) begin own1 = 0; own2 = 0; end
      exp1 = {e_dg, e_wg, e_we, e_addr, e_wdata, own1 == 1, own1 == 1 ? mem_rdata : 16'h0,
              own1 == 2, own1 == 2 ? mem_rdata : 16'h0};
      exp2 = {e_dg, e_wg, e_we, e_addr, e_wdata, own2 == 1, own2 == 1 ? mem_rdata : 16'h0,
              own2 == 2, own2 == 2 ? mem_rdata : 16'h0};
      act1 = {bus1.disp_gnt, bus1.draw_gnt, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata,
              bus1.disp_rvalid, bus1.disp_rdata, bus1.draw_rvalid, bus1.draw_rdata};
      act2 = {bus2.disp_gnt, bus2.draw_gnt, bus2.mem_we, bus2.mem_addr, bus2.mem_wdata,
              bus2.disp_rvalid, bus2.disp_rdata, bus2.draw_rvalid, bus2.draw_rdata};
      n_run++;
      if (act1 !== exp1) begin
        n_fail++;
        $display("FAIL rand_lat1 cyc%0d: got %h required %h", c, act1, exp1);
      end
      n_run++;
      if (act2 !== exp2) begin
        n_fail++;
        $display("FAIL rand_lat2 cyc%0d: got %h required %h", c, act2, exp2);
      end
      @(posedge clk);
      if (reset) begin
        streak = 0;
        forced = 1'b0;
        acc.delete();
      end else begin
        if (forced) begin
          forced = 1'b0;
          streak = 0;
        end else begin
          if (draw_req && !e_wg) streak = (streak < STARVE_MAX) ? streak + 1 : STARVE_MAX;
          else                   streak = 0;
          forced = (streak == STARVE_MAX);
        end
        if (e_dg)                 acc.push_back('{now, 1});
        else if (e_wg && !e_we)   acc.push_back('{now, 2});
      end
      while (acc.size() > 0 && acc[0].cyc < now - 3) void'(acc.pop_front());
      now++;
      #1;
      if (e_dg || reset) disp_req = 1'b0;
      if (e_wg || reset) draw_req = 1'b0;
    end
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_stats();
`ifdef ARB_STATS_EN
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    disp_req = 1'b1;
    draw_req = 1'b1;
    repeat (20) tick();
    idle_inputs();
    @(negedge clk);
    n_run++;
    if ({s1_disp_cnt, s1_draw_cnt, s1_force_cnt} !== {32'd18, 32'd2, 16'd2}) begin
      n_fail++;
      $display("FAIL stats_lat1: got disp=%0d draw=%0d force=%0d required 18 2 2",
               s1_disp_cnt, s1_draw_cnt, s1_force_cnt);
    end
    n_run++;
    if ({s2_disp_cnt, s2_draw_cnt, s2_force_cnt} !== {32'd18, 32'd2, 16'd2}) begin
      n_fail++;
      $display("FAIL stats_lat2: got disp=%0d draw=%0d force=%0d required 18 2 2",
               s2_disp_cnt, s2_draw_cnt, s2_force_cnt);
    end
    tick();
`endif
  endtask

  initial begin
    reset     = 1'b1;
    mem_rdata = '0;
    idle_inputs();
    tick();
    test_reset();
    test_disp_read();
    test_starvation();
    test_write_boundary();
    test_alternating();
    test_reset_midflight();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares port B of the dual-port `ram_block` between two requesters:
  - the VGA display fetch engine, which is read-only;
  - the canvas draw engine, which reads and writes.
- Display has fixed priority. Draw is protected from starvation by a bounded-wait counter.
- Sits between the two engines and the `b_address`/`b_writeData`/`b_we`/`b_out` pins of `ram_block`. Port A stays dedicated to the CPU.

Parameters:
- ADDR_W, 12, word address width; equals `addr[15:4]` of the 16-bit byte address.
- DATA_W, 16, data width.
- RD_LAT, 1, RAM read latency in cycles; legal range 1..4.
- STARVE_MAX, 8, consecutive denied cycles before draw is forced; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display word address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rvalid  out  1  display read data valid.
- disp_rdata  out  DATA_W  display read data.
- draw_req  in  1  draw request.
- draw_we  in  1  1 = write, 0 = read.
- draw_addr  in  ADDR_W  draw word address.
- draw_wdata  in  DATA_W  draw write data.
- draw_gnt  out  1  draw request accepted this cycle.
- draw_rvalid  out  1  draw read data valid.
- draw_rdata  out  DATA_W  draw read data.
- mem_addr  out  ADDR_W  to `ram_block` `b_address`.
- mem_wdata  out  DATA_W  to `b_writeData`.
- mem_we  out  1  to `b_we`.
- mem_rdata  in  DATA_W  from `b_out`.

Behaviour:
- Handshake:
  - A request is accepted in the cycle where req=1 and gnt=1.
  - gnt is combinational from req and registered state.
  - The requester holds req, addr, we and wdata stable until accepted.
  - Back-to-back acceptance on consecutive cycles is allowed. Throughput is 1 access per cycle.
- Mem side:
  - mem_addr, mem_wdata and mem_we are combinational from the winning requester.
  - mem_we = draw_gnt & draw_we.
  - When idle: mem_we=0, mem_addr=0, mem_wdata=0.
- FSM, registered, states PRIO_DISP and FORCE_DRAW:
  - PRIO_DISP:
    - If disp_req=1, grant display.
    - Else if draw_req=1, grant draw.
    - If draw_req=1 and draw is denied, starve_cnt increments, saturating at STARVE_MAX.
    - If starve_cnt reaches STARVE_MAX, move to FORCE_DRAW at the next edge.
  - FORCE_DRAW:
    - If draw_req=1, grant draw unconditionally and deny display.
    - Then return to PRIO_DISP with starve_cnt=0.
    - If draw_req has dropped, return to PRIO_DISP with no grant given.
- starve_cnt clears on any draw grant, and on any cycle with draw_req=0.
- Never assert both grants in one cycle.
- Read return:
  - Each accepted read pushes an owner tag (display or draw) into an RD_LAT-deep shift register.
  - RD_LAT cycles after acceptance, the matching rvalid pulses for exactly 1 cycle.
  - Both rdata outputs are driven with mem_rdata whenever their rvalid is 1, and are 0 otherwise.
  - Writes push a no-owner tag, so no rvalid is produced for them.
- Reset:
  - The FSM goes to PRIO_DISP and starve_cnt goes to 0.
  - The tag pipeline is flushed, so in-flight reads are dropped and never return rvalid.
  - All gnt, rvalid, rdata and mem_we outputs are 0 while reset=1.
  - Reset asserted mid-burst drops the pending request. The requester must re-request after reset.
- Boundary cases:
  - Address 0 and address 2^ADDR_W-1 pass through unchanged; there is no wrap arithmetic.
  - A draw write and a display read to the same address in consecutive cycles are served in grant order. The read returns the RAM's value per `ram_block` semantics.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, add the following output ports, all synchronously cleared by reset:
  - disp_grant_cnt (32): increments on each display grant and wraps.
  - draw_grant_cnt (32): increments on each draw grant and wraps.
  - force_cnt (16): increments on each FORCE_DRAW entry and saturates at 0xFFFF.
- When undefined, these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Reset, then disp_req=1 at addr 0x010 with mem_rdata=0xBEEF: disp_gnt=1 the same cycle, mem_addr=0x010, disp_rvalid=1 and disp_rdata=0xBEEF exactly 1 cycle later; draw_rvalid stays 0.
- disp_req and draw_req both held continuously, STARVE_MAX=8: display granted 8 cycles, draw granted on cycle 9, display granted on cycle 10; the pattern repeats every 9 cycles.
- draw write addr 0xFFF, wdata 0x1234, display idle: draw_gnt=1 and mem_we=1 for 1 cycle, mem_addr=0xFFF, mem_wdata=0x1234; no rvalid follows.
- Alternating display read at 0x020 and draw read at 0x021, RD_LAT=2: each rvalid pulses 2 cycles after its own grant and the tags never cross.
- Draw read accepted, reset asserted the next cycle: no draw_rvalid ever appears; all outputs are 0 during reset; the FSM is back in PRIO_DISP after reset.
- With ARB_STATS_EN and 20 cycles of contention: disp_grant_cnt=18, draw_grant_cnt=2, force_cnt=2.
